// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline/memory signal bundle for the fetch/data memory arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch stage
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // data-memory stage
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  // single-ported memory
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  // pipeline control
  logic              stall_if;
  logic              stall_mem;
  logic              protocol_err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, ram_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid,
           ram_en, ram_we, ram_addr, ram_wdata,
           stall_if, stall_mem, protocol_err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, ram_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid,
           ram_en, ram_we, ram_addr, ram_wdata,
           stall_if, stall_mem, protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data stages
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [STV_W-1:0]  starve_q;
  logic              win_if_q;
  logic              win_wr_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              protocol_err_q;

  logic dm_req;
  logic starved;
  logic grant;
  logic grant_if;

  assign dm_req  = bus.dm_rd | bus.dm_wr;
  assign starved = (starve_q == STV_W'(STARVE_MAX));

  // State register; reset drops any in-flight access on the spot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and grant decision; data wins unless fetch has starved
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || dm_req) begin
          grant    = 1'b1;
          grant_if = bus.if_req & (~dm_req | starved);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        // requester still holds its completed request, so never re-arbitrate here
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobe, latency/starvation counters, read capture and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      starve_q       <= '0;
      win_if_q       <= 1'b0;
      win_wr_q       <= 1'b0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      if_valid_q     <= 1'b0;
      dm_valid_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.if_req) starve_q <= '0;
          if (grant) begin
            ram_en_q <= 1'b1;
            cnt_q    <= CNT_W'(LAT);
            win_if_q <= grant_if;
            if (bus.dm_rd && bus.dm_wr) protocol_err_q <= 1'b1;
            if (grant_if) begin
              ram_addr_q <= bus.if_addr;
              win_wr_q   <= 1'b0;
              starve_q   <= '0;
            end else begin
              // a simultaneous rd+wr is carried out as a write
              ram_addr_q  <= bus.dm_addr;
              ram_we_q    <= bus.dm_wr;
              ram_wdata_q <= bus.dm_wdata;
              win_wr_q    <= bus.dm_wr;
              if (bus.if_req && !starved) starve_q <= starve_q + STV_W'(1);
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            if (win_if_q)       if_rdata_q <= bus.ram_rdata;
            else if (!win_wr_q) dm_rdata_q <= bus.ram_rdata;
            if_valid_q <= win_if_q;
            dm_valid_q <= ~win_if_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_en       = ram_en_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.dm_valid     = dm_valid_q;
  assign bus.protocol_err = protocol_err_q;
  assign bus.stall_if     = bus.if_req & ~if_valid_q;
  assign bus.stall_mem    = dm_req & ~dm_valid_q;

endmodule
